// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the Yu Core data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int XLEN = 32;

    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester handshakes plus the DataMem port; the slave side is the arbiter.
interface dmem_arbiter_if;

    logic                               req0_valid;
    logic                               req0_ready;
    logic                               req0_we;
    logic [dmem_arbiter_pkg::XLEN-1:0]  req0_addr;
    logic [dmem_arbiter_pkg::XLEN-1:0]  req0_wdata;
    logic                               rsp0_valid;
    logic [dmem_arbiter_pkg::XLEN-1:0]  rsp0_rdata;

    logic                               req1_valid;
    logic                               req1_ready;
    logic                               req1_we;
    logic [dmem_arbiter_pkg::XLEN-1:0]  req1_addr;
    logic [dmem_arbiter_pkg::XLEN-1:0]  req1_wdata;
    logic                               rsp1_valid;
    logic [dmem_arbiter_pkg::XLEN-1:0]  rsp1_rdata;

    logic [dmem_arbiter_pkg::XLEN-1:0]  address;
    logic [dmem_arbiter_pkg::XLEN-1:0]  writeData;
    logic                               writeEnable;
    logic                               readEnable;
    logic [dmem_arbiter_pkg::XLEN-1:0]  readData;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output address, writeData, writeEnable, readEnable,
        input  readData
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  address, writeData, writeEnable, readEnable,
        output readData
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, contention goes to
// whoever did not win last time.
module dmem_arbiter_rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);

    assign grant0 = valid0 && (!valid1 || (last_grant == REQ_LOADER));
    assign grant1 = valid1 && (!valid0 || (last_grant == REQ_CORE));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the DataMem port between the core and the loader: accept, one access
// cycle, one response cycle, then back to idle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    state_t           state;
    logic             last_grant;
    logic             lat_id;
    logic             lat_we;
    logic             grant0;
    logic             grant1;
    logic             ready0;
    logic             ready1;
    logic [XLEN-1:0]  address_q;
    logic [XLEN-1:0]  write_data_q;
    logic             write_enable_q;
    logic             read_enable_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;

    dmem_arbiter_rr_arbiter2 u_rr (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    // Ready is masked during reset so nothing can be accepted on a reset edge.
    assign ready0 = (state == ST_IDLE) && grant0 && !rst;
    assign ready1 = (state == ST_IDLE) && grant1 && !rst;

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.address     = address_q;
    assign bus.writeData   = write_data_q;
    assign bus.writeEnable = write_enable_q;
    assign bus.readEnable  = read_enable_q;

    // readData arrives in the response cycle itself, so read data is steered
    // combinationally; writes return zero.
    assign bus.rsp0_valid = rsp0_valid_q && !rst;
    assign bus.rsp1_valid = rsp1_valid_q && !rst;
    assign bus.rsp0_rdata = (rsp0_valid_q && !lat_we && !rst) ? bus.readData : '0;
    assign bus.rsp1_rdata = (rsp1_valid_q && !lat_we && !rst) ? bus.readData : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            last_grant     <= REQ_LOADER;
            lat_id         <= REQ_CORE;
            lat_we         <= 1'b0;
            address_q      <= '0;
            write_data_q   <= '0;
            write_enable_q <= 1'b0;
            read_enable_q  <= 1'b0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ready0 || ready1) begin
                        lat_id         <= ready1;
                        last_grant     <= ready1;
                        lat_we         <= ready1 ? bus.req1_we : bus.req0_we;
                        address_q      <= ready1 ? bus.req1_addr : bus.req0_addr;
                        write_data_q   <= ready1 ? bus.req1_wdata : bus.req0_wdata;
                        write_enable_q <= ready1 ? bus.req1_we : bus.req0_we;
                        read_enable_q  <= ready1 ? !bus.req1_we : !bus.req0_we;
                        state          <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    address_q      <= '0;
                    write_data_q   <= '0;
                    write_enable_q <= 1'b0;
                    read_enable_q  <= 1'b0;
                    rsp0_valid_q   <= (lat_id == REQ_CORE);
                    rsp1_valid_q   <= (lat_id == REQ_LOADER);
                    state          <= ST_RESP;
                end
                ST_RESP: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    address_q      <= '0;
                    write_data_q   <= '0;
                    write_enable_q <= 1'b0;
                    read_enable_q  <= 1'b0;
                    rsp0_valid_q   <= 1'b0;
                    rsp1_valid_q   <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed DataMem model.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;
    logic [31:0] mem [0:63];

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMem model: registered read, valid the cycle after readEnable.
    always @(posedge clk) begin
        if (bus.writeEnable) mem[bus.address[7:2]] <= bus.writeData;
        if (bus.readEnable)  bus.readData <= mem[bus.address[7:2]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        bus.req0_valid = v0;
        bus.req0_we    = w0;
        bus.req0_addr  = a0;
        bus.req0_wdata = d0;
        bus.req1_valid = v1;
        bus.req1_we    = w1;
        bus.req1_addr  = a1;
        bus.req1_wdata = d1;
        #1;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // One isolated transaction from requester id; the payload is scrambled
    // right after accept to show the latched copy is what reaches memory.
    task automatic runTxn(input logic id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] expRdata);
        if (id) applyStimulus(0, 0, 0, 0, 1, we, addr, wdata);
        else    applyStimulus(1, we, addr, wdata, 0, 0, 0, 0);
        checkOutput("txn_ready0", bus.req0_ready, !id);
        checkOutput("txn_ready1", bus.req1_ready, id);
        waitCycle();
        if (id) applyStimulus(0, 0, 0, 0, 0, !we, 32'hFFFF_FFFC, ~wdata);
        else    applyStimulus(0, !we, 32'hFFFF_FFFC, ~wdata, 0, 0, 0, 0);
        checkOutput("acc_writeEnable", bus.writeEnable, we);
        checkOutput("acc_readEnable", bus.readEnable, !we);
        checkOutput("acc_address", bus.address, addr);
        checkOutput("acc_writeData", bus.writeData, wdata);
        waitCycle();
        checkOutput("rsp_valid0", bus.rsp0_valid, !id);
        checkOutput("rsp_valid1", bus.rsp1_valid, id);
        checkOutput("rsp_rdata0", bus.rsp0_rdata, (!id && !we) ? expRdata : 32'h0);
        checkOutput("rsp_rdata1", bus.rsp1_rdata, (id && !we) ? expRdata : 32'h0);
        checkOutput("rsp_enables", {bus.writeEnable, bus.readEnable}, 32'h0);
        waitCycle();
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        bus.readData = '0;
        rst = 1'b1;
        applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);

        // Reset held two cycles with both valids high.
        for (int i = 0; i < 2; i++) begin
            waitCycle();
            checkOutput("rst_ready", {bus.req0_ready, bus.req1_ready}, 32'h0);
            checkOutput("rst_mem", {bus.writeEnable, bus.readEnable}, 32'h0);
            checkOutput("rst_address", bus.address, 32'h0);
            checkOutput("rst_writeData", bus.writeData, 32'h0);
            checkOutput("rst_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 32'h0);
            checkOutput("rst_rdata", bus.rsp0_rdata | bus.rsp1_rdata, 32'h0);
        end
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready0", bus.req0_ready, 1'b1);
        checkOutput("post_rst_ready1", bus.req1_ready, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitCycle();
        checkOutput("idle_hold", {bus.readEnable, bus.writeEnable}, 32'h0);

        $display("[TB] loader write/read and preload");
        runTxn(1, 1, 32'h10, 32'hDEAD_BEEF, 32'h0);
        runTxn(1, 0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        runTxn(1, 1, 32'h0, 32'h1111_1111, 32'h0);
        runTxn(1, 1, 32'h4, 32'h2222_2222, 32'h0);
        runTxn(1, 1, 32'h8, 32'h3333_3333, 32'h0);

        // Last grant was the loader, so the core wins first and grants alternate.
        $display("[TB] contention");
        applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("cont_ready0", bus.req0_ready, (k % 2) == 0);
            checkOutput("cont_ready1", bus.req1_ready, (k % 2) == 1);
            waitCycle();
            checkOutput("cont_readEnable", bus.readEnable, 1'b1);
            checkOutput("cont_address", bus.address, ((k % 2) == 1) ? 32'h4 : 32'h0);
            checkOutput("cont_acc_ready", {bus.req0_ready, bus.req1_ready}, 32'h0);
            waitCycle();
            checkOutput("cont_rsp0", bus.rsp0_valid, (k % 2) == 0);
            checkOutput("cont_rsp1", bus.rsp1_valid, (k % 2) == 1);
            checkOutput("cont_rdata0", bus.rsp0_rdata, ((k % 2) == 0) ? 32'h1111_1111 : 32'h0);
            checkOutput("cont_rdata1", bus.rsp1_rdata, ((k % 2) == 1) ? 32'h2222_2222 : 32'h0);
            waitCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitCycle();

        $display("[TB] back-to-back core reads");
        applyStimulus(1, 0, 32'h8, 0, 0, 0, 0, 0);
        for (int c = 0; c < 9; c++) begin
            checkOutput("b2b_ready0", bus.req0_ready, (c % 3) == 0);
            checkOutput("b2b_readEnable", bus.readEnable, (c % 3) == 1);
            checkOutput("b2b_rsp0", bus.rsp0_valid, (c % 3) == 2);
            checkOutput("b2b_rdata0", bus.rsp0_rdata, ((c % 3) == 2) ? 32'h3333_3333 : 32'h0);
            waitCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitCycle();

        $display("[TB] payload stability");
        runTxn(0, 0, 32'h4, 32'h0, 32'h2222_2222);

        // Core won last, so only the reset can hand the next contention back to it.
        $display("[TB] reset during access");
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 0, 0);
        checkOutput("mid_ready0", bus.req0_ready, 1'b1);
        waitCycle();
        checkOutput("mid_access_re", bus.readEnable, 1'b1);
        rst = 1'b1;
        applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        checkOutput("mid_rst_ready", {bus.req0_ready, bus.req1_ready}, 32'h0);
        waitCycle();
        rst = 1'b0;
        #1;
        checkOutput("mid_no_rsp0", bus.rsp0_valid, 1'b0);
        checkOutput("mid_no_rdata0", bus.rsp0_rdata, 32'h0);
        checkOutput("mid_no_enable", {bus.writeEnable, bus.readEnable}, 32'h0);
        checkOutput("mid_idle_ready0", bus.req0_ready, 1'b1);
        checkOutput("mid_idle_ready1", bus.req1_ready, 1'b0);
        waitCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mid_re_access", bus.readEnable, 1'b1);
        checkOutput("mid_re_address", bus.address, 32'h0);
        waitCycle();
        checkOutput("mid_re_rsp0", bus.rsp0_valid, 1'b1);
        checkOutput("mid_re_rsp1", bus.rsp1_valid, 1'b0);
        checkOutput("mid_re_rdata0", bus.rsp0_rdata, 32'h1111_1111);
        waitCycle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared data memory (DataMem) port of Yu Core.
- Requester 0 is the core load/store path. Requester 1 is the test/loader port used by benches and the program loader to preload or inspect data memory.
- Latches one request, drives the DataMem address/writeData/writeEnable/readEnable for exactly one cycle, captures readData, and returns a one-cycle response to the winner.

Parameters:
- XLEN, 32, data/address width; taken from Parameters.vh.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_we  in  1  1 = write, 0 = read
- req0_addr  in  XLEN  byte address
- req0_wdata  in  XLEN  write data
- rsp0_valid  out  1  response pulse for requester 0
- rsp0_rdata  out  XLEN  read data, 0 for writes
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1
- address  out  XLEN  to DataMem
- writeData  out  XLEN  to DataMem
- writeEnable  out  1  to DataMem
- readEnable  out  1  to DataMem
- readData  in  XLEN  from DataMem, valid the cycle after readEnable

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst. The polarity and synchronicity are fixed.
- Reset values:
  - All outputs 0; state IDLE.
  - last_grant = 1, so requester 0 wins the first contention.
- States:
  - IDLE: reqN_ready is combinational and equals (state==IDLE && grantN).
    - Only one valid request: grant it.
    - Both valid: grant the requester that is not last_grant.
    - On accept, latch we/addr/wdata and grant id, update last_grant, go to ACCESS.
    - No valid request: stay in IDLE.
  - ACCESS: exactly one cycle.
    - address and writeData come from the latch.
    - writeEnable = latched we; readEnable = !latched we.
    - Go to RESP.
  - RESP: exactly one cycle.
    - rspN_valid = 1 for the granted requester only.
    - rspN_rdata = readData for reads, 0 for writes.
    - Go to IDLE.
- Outside ACCESS, address, writeData, writeEnable and readEnable are all 0. Outside RESP, rsp*_valid is 0 and rsp*_rdata is 0.
- Latency and throughput:
  - Accept at cycle T, memory access at T+1, response at T+2.
  - One transaction per 3 cycles. The next accept is possible at T+3.
- reqN_ready is never high in ACCESS or RESP. A requester holds valid and payload until ready; payload changes after accept are ignored.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1. The maximum wait for either requester is one transaction.
- A requester dropping valid before ready is legal; nothing is latched for it.
- Reset mid-operation (in ACCESS or RESP):
  - Return to IDLE on the next edge.
  - No response pulse is produced and no further memory enable is asserted.
  - A write already presented in ACCESS on the reset edge is not retracted.
- rsp valid is never asserted to both requesters, and never to the non-granted one.
- No alignment checking; the address is passed through unchanged.

Decomposition:
- Shared package/header, in Parameters.vh: XLEN; state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2; requester ids REQ_CORE=1'b0, REQ_LOADER=1'b1.
- One natural sub-module: rr_arbiter2. It is combinational, taking valid0, valid1 and last_grant and producing grant0 and grant1. The FSM, latches and muxing stay in dmem_arbiter.

Test Plan:
- Reset then idle: hold rst 2 cycles with both valids high -> all outputs 0 during reset; after release, req0_ready=1 in the first cycle.
- Single write then read on requester 1:
  - Write addr 0x10, wdata 0xDEADBEEF -> writeEnable=1, address=0x10 at T+1; rsp1_valid=1, rsp1_rdata=0 at T+2.
  - Read 0x10 -> readEnable=1 at T+1; rsp1_rdata=0xDEADBEEF at T+2; rsp0_valid stays 0.
- Contention: both valid continuously, reading 0x0 and 0x4 -> accepts at T, T+3, T+6, T+9 granted 0,1,0,1; each rsp pulse is 1 cycle and goes to the matching requester.
- Back-to-back single requester: req0 valid for 3 transactions -> ready at T, T+3, T+6; readEnable never high on consecutive cycles.
- Reset mid-operation: assert rst in the ACCESS cycle of a requester 0 read -> no rsp0_valid; next cycle IDLE; the following request accepts normally with requester 0 winning contention.
- Payload stability: change req0_addr after accept -> the memory address still equals the latched value.
